regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle register file: clocked multi-port register file plus a per-register pending-write scoreboard.
- Serves the pipelined core. Decode reads operands and busy flags and issues destination registers; writeback ports retire results.
- Register 0 is hardwired to zero and is never busy.
- Same-cycle write-to-read forwarding is optional.

Parameters:
- XLEN, 32, data word width in bits.
- REG_COUNT, 32, number of architectural registers (power of two, ≥2).
- NUM_RD, 2, number of combinational read ports.
- NUM_WR, 2, number of writeback ports.
- ADDR_W, $clog2(REG_COUNT), register address width (derived; do not override).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rd_addr  input  NUM_RD x ADDR_W  read port addresses.
- rd_data  output  NUM_RD x XLEN  read data.
- rd_busy  output  NUM_RD  addressed register has a pending write.
- wr_en  input  NUM_WR  writeback enables.
- wr_addr  input  NUM_WR x ADDR_W  writeback destinations.
- wr_data  input  NUM_WR x XLEN  writeback data.
- issue_en  input  1  mark a destination register pending.
- issue_rd  input  ADDR_W  destination register to mark.
- flush  input  1  synchronous clear of all busy bits (pipeline flush).
- busy_vec  output  REG_COUNT  full scoreboard, for debug/hazard unit.

Behaviour:
- Reset: clk and rst_n are the only clock and reset; rst_n is asynchronous and active-low. On reset assertion, all registers become 0 and all busy bits become 0 immediately. Outputs: rd_data = 0, rd_busy = 0, busy_vec = 0.
- Reads are combinational, with zero latency from rd_addr. rd_addr == 0 always gives rd_data = 0 and rd_busy = 0.
- Writes are synchronous. At the rising edge with wr_en[i] = 1 and wr_addr[i] != 0, regs[wr_addr[i]] <= wr_data[i]. Writes to address 0 are ignored.
- Write conflict: if several ports target the same register in one cycle, the highest port index wins. This is deterministic, not an error.
- Scoreboard per register r (r != 0), next-state priority, highest first:
  1. flush → 0
  2. issue_en && issue_rd == r → 1
  3. any wr_en[i] && wr_addr[i] == r → 0
  4. otherwise hold
- Issue and writeback to the same register in the same cycle leaves it busy, because the new producer supersedes the old one.
- issue_en with issue_rd == 0 has no effect.
- flush does not alter register contents; writebacks in the flush cycle still commit their data.
- Writeback to a register that is not busy is legal: data commits and busy stays 0.
- busy_vec[0] is always 0.
- Reset mid-operation: asynchronous clear overrides everything, and same-cycle writes are lost.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If wr_en[i] and wr_addr[i] == rd_addr[j] != 0 in the same cycle, rd_data[j] = wr_data[i], taking the highest matching i. rd_busy[j] is also forced to 0 unless the same cycle has issue_en with issue_rd == rd_addr[j] and no flush.
- Undefined: reads return the pre-edge register contents and the pre-edge busy bit. The written value is visible from the next cycle.

Decomposition:
- types_pkg holds: word_t, reg_addr_t, REG_COUNT, plus a new rf_busy_t (logic [REG_COUNT-1:0]).
- One natural sub-module: regfile_scoreboard, containing the busy-bit array with issue/writeback/flush priority logic and busy_vec output.
- The top level holds the storage array, write-port priority and the optional bypass mux.

Test Plan:
- Reset: drive rst_n = 0 mid-cycle after writing 0xDEADBEEF to x5 → rd_data for x5 = 0 and busy_vec = 0 immediately, with no clock edge needed.
- x0: write 0x1234 to x0 and issue x0 → reads of x0 return 0 and rd_busy = 0 forever.
- Conflict: wr port0 x7 = 0xAAAA and port1 x7 = 0x5555 in one cycle → next cycle x7 reads 0x5555.
- Scoreboard: issue x3 → busy next cycle. Writeback x3 = 0x42 → busy clears next cycle and x3 = 0x42. Issue plus writeback of x3 in the same cycle → x3 stays busy with data 0x42.
- Flush: issue x1, x2, x9, then flush with a same-cycle writeback x2 = 0x77 → busy_vec = 0 and x2 = 0x77.
- Bypass: read x4 while writing 0xCAFE to x4. With REGFILE_BYPASS_EN → rd_data = 0xCAFE the same cycle and rd_busy = 0. Without it → old value this cycle, 0xCAFE the next cycle.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types and default sizing for the register file with pending-write scoreboard.
package types_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned NUM_RD    = 2;
  localparam int unsigned NUM_WR    = 2;
  localparam int unsigned ADDR_W    = $clog2(REG_COUNT);

  typedef logic [XLEN-1:0]      word_t;
  typedef logic [ADDR_W-1:0]    reg_addr_t;
  typedef logic [REG_COUNT-1:0] rf_busy_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: flush beats issue, issue beats writeback clear.
module regfile_scoreboard #(
  parameter int unsigned REG_COUNT = types_pkg::REG_COUNT,
  parameter int unsigned NUM_WR    = types_pkg::NUM_WR,
  parameter int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic                           issue_en,
  input  logic [ADDR_W-1:0]              issue_rd,
  input  logic                           flush,
  output logic [REG_COUNT-1:0]           busy_vec
);

  logic [REG_COUNT-1:0] busy_nxt;

  // Apply lowest priority first so later assignments override.
  always_comb begin
    busy_nxt = busy_vec;
    for (int i = 0; i < int'(NUM_WR); i++) begin
      if (wr_en[i]) busy_nxt[wr_addr[i]] = 1'b0;
    end
    if (issue_en) busy_nxt[issue_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with pending-write scoreboard; x0 reads as zero, never busy.
// Define REGFILE_BYPASS_EN for write-first forwarding of same-cycle writebacks to reads.
module regfile_sb #(
  parameter int unsigned XLEN      = types_pkg::XLEN,
  parameter int unsigned REG_COUNT = types_pkg::REG_COUNT,
  parameter int unsigned NUM_RD    = types_pkg::NUM_RD,
  parameter int unsigned NUM_WR    = types_pkg::NUM_WR,
  parameter int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]    rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data,
  input  logic                           issue_en,
  input  logic [ADDR_W-1:0]              issue_rd,
  input  logic                           flush,
  output logic [REG_COUNT-1:0]           busy_vec
);

  logic [XLEN-1:0] regs [REG_COUNT];

  // Later ports are applied last, so the highest index wins a conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(REG_COUNT); r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_WR); i++) begin
        if (wr_en[i] && (wr_addr[i] != '0)) regs[wr_addr[i]] <= wr_data[i];
      end
    end
  end

  regfile_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .NUM_WR    (NUM_WR),
    .ADDR_W    (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < int'(NUM_RD); j++) begin
      if (rd_addr[j] != '0) begin
        rd_data[j] = regs[rd_addr[j]];
        rd_busy[j] = busy_vec[rd_addr[j]];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < int'(NUM_WR); i++) begin
          if (wr_en[i] && (wr_addr[i] == rd_addr[j])) begin
            rd_data[j] = wr_data[i];
            rd_busy[j] = issue_en && (issue_rd == rd_addr[j]) && !flush;
          end
        end
`endif
      end
    end
  end

endmodule
